shift_deserializer: RTL and testbench

Serial-in, parallel-out receiver for the MSB-first left-shift serial stream produced by the parallel-load shifter. A start strobe marks the first (most significant) bit. The block collects WIDTH consecutive bits into a word and presents it to downstream logic on a one-entry valid/ready output register. It also flags words lost to backpressure.

---
 rtl/shift_deserializer.sv | 91 +++++++++
 tb/tb_shift_deserializer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/shift_deserializer.sv
// Serial-in, parallel-out receiver for an MSB-first serial stream.
// Collects WIDTH bits after a start strobe into a word and presents it on a
// one-entry valid/ready output register. A sticky flag records words that
// were dropped because the output register was still full.
module shift_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_bit,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_overrun
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count, count_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [WIDTH-1:0] word;
  logic             done;

  // Next-state logic: a start strobe always begins a fresh frame, even one
  // that lands on the completion cycle, so the completing word is discarded.
  always_comb begin
    state_next = state;
    count_next = count;
    shreg_next = shreg;
    done       = 1'b0;
    word       = {shreg[WIDTH-2:0], i_bit};
    if (i_start) begin
      state_next = SHIFT;
      count_next = CW'(1);
      shreg_next = {{(WIDTH-1){1'b0}}, i_bit};
    end else if (state == SHIFT) begin
      shreg_next = word;
      if (count == CW'(WIDTH - 1)) begin
        done       = 1'b1;
        state_next = IDLE;
        count_next = '0;
      end else begin
        count_next = count + CW'(1);
      end
    end
  end

  // State, shift register and bit counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      count <= '0;
      shreg <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      shreg <= shreg_next;
    end
  end

  // Output register: load on completion when empty or being drained in the
  // same cycle; otherwise drop the new word and raise the sticky overrun.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else if (done) begin
      if (!o_valid || i_ready) begin
        o_data  <= word;
        o_valid <= 1'b1;
      end else begin
        o_overrun <= 1'b1;
      end
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

  // Busy mirrors the registered state.
  always_comb o_busy = (state == SHIFT);

endmodule

// File: tb/tb_shift_deserializer.sv
// Bench for shift_deserializer (WIDTH = 8): directed frames; expected words
// go into a queue and a monitor compares them at each output handshake.
module tb_shift_deserializer;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic       i_bit = 1'b0;
  logic       i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_busy;
  logic       o_overrun;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  shift_deserializer #(.WIDTH(8)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_bit    (i_bit),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_busy   (o_busy),
    .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then move to just after the next edge.
  task automatic step(input logic s, input logic b, input logic r, input logic rst);
    i_start = s;
    i_bit   = b;
    i_ready = r;
    i_rst   = rst;
    @(posedge i_clk);
    #1;
  endtask

  // Send one 8-bit frame; checks busy every cycle and valid in cycles 1..7.
  task automatic send_frame(input logic [7:0] w, input logic rdy, input logic mid_valid);
    for (int k = 0; k < 8; k++) begin
      step(k == 0, w[7-k], rdy, 1'b0);
      if (k < 7) begin
        check("busy_mid", {31'b0, o_busy}, 32'd1);
        check("valid_mid", {31'b0, o_valid}, {31'b0, mid_valid});
      end else begin
        check("busy_end", {31'b0, o_busy}, 32'd0);
      end
    end
  endtask

  // Scoreboard monitor: every handshake must match the next expected word.
  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got=%0h expected=none at %0t", o_data, $time);
      end else begin
        check("word", {24'b0, o_data}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    logic [7:0] partial;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    i_rst = 1'b0;
    check("rst_data", {24'b0, o_data}, 32'h0);
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_overrun", {31'b0, o_overrun}, 32'd0);

    // 0xA5, ready high: valid only in cycle 8
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5_valid8", {31'b0, o_valid}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("a5_valid9", {31'b0, o_valid}, 32'd0);
    check("a5_overrun", {31'b0, o_overrun}, 32'd0);

    // 0x3C held under backpressure until cycle 12
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b0);
    check("3c_valid8", {31'b0, o_valid}, 32'd1);
    for (int c = 8; c < 12; c++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("3c_hold_valid", {31'b0, o_valid}, 32'd1);
      check("3c_hold_data", {24'b0, o_data}, 32'h3C);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("3c_valid13", {31'b0, o_valid}, 32'd0);

    // back-to-back 0x01, 0x80
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    send_frame(8'h01, 1'b1, 1'b0);
    check("b2b_valid8", {31'b0, o_valid}, 32'd1);
    send_frame(8'h80, 1'b1, 1'b0);
    check("b2b_valid16", {31'b0, o_valid}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("b2b_valid17", {31'b0, o_valid}, 32'd0);

    // 0x11 then 0x22 with ready low: 0x22 dropped, overrun sticky
    send_frame(8'h11, 1'b0, 1'b0);
    check("ovr_valid8", {31'b0, o_valid}, 32'd1);
    check("ovr_overrun8", {31'b0, o_overrun}, 32'd0);
    send_frame(8'h22, 1'b0, 1'b1);
    check("ovr_valid16", {31'b0, o_valid}, 32'd1);
    check("ovr_data16", {24'b0, o_data}, 32'h11);
    check("ovr_overrun16", {31'b0, o_overrun}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("ovr_sticky", {31'b0, o_overrun}, 32'd1);
      check("ovr_data_hold", {24'b0, o_data}, 32'h11);
    end

    // reset in cycle 5 of a frame while 0x11 is still buffered
    partial = 8'hE7;
    for (int k = 0; k < 5; k++) step(k == 0, partial[7-k], 1'b0, 1'b0);
    step(1'b0, partial[2], 1'b0, 1'b1);
    check("mrst_data", {24'b0, o_data}, 32'h0);
    check("mrst_valid", {31'b0, o_valid}, 32'd0);
    check("mrst_busy", {31'b0, o_busy}, 32'd0);
    check("mrst_overrun", {31'b0, o_overrun}, 32'd0);
    step(1'b0, partial[1], 1'b1, 1'b0);
    step(1'b0, partial[0], 1'b1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check("mrst_no_valid", {31'b0, o_valid}, 32'd0);
    end
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0);
    check("c3_valid8", {31'b0, o_valid}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("c3_valid9", {31'b0, o_valid}, 32'd0);

    // restart: four 1s, then new start at cycle 4 with 0x5A
    for (int k = 0; k < 4; k++) begin
      step(k == 0, 1'b1, 1'b1, 1'b0);
      check("rs_pre_valid", {31'b0, o_valid}, 32'd0);
    end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    check("rs_valid12", {31'b0, o_valid}, 32'd1);
    check("rs_overrun", {31'b0, o_overrun}, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("rs_valid13", {31'b0, o_valid}, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
